// File: rtl/fir_decim_reader.sv
// Accumulate-and-dump decimator (factor 2^DECIM_LOG2) on the FIR output stream, feeding a
// 4-entry first-word-fall-through FIFO drained over a valid/ready handshake.
module fir_decim_reader #(
  parameter int unsigned DECIM_LOG2 = 2,
  parameter int unsigned DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] y_in,
  input  logic        in_en,
  output logic [23:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [2:0]  fill,
  output logic        ovf,
  input  logic        clr_ovf
);

  localparam int unsigned AccW = 24 + DECIM_LOG2;

  logic [DECIM_LOG2-1:0] phase;
  logic [AccW-1:0]       acc;
  logic [AccW-1:0]       sum;
  logic [23:0]           word;
  logic [23:0]           mem [DEPTH];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            fill_q;
  logic [2:0]            fill_d;
  logic                  ovf_q;
  logic                  dump;
  logic                  full;
  logic                  pop;
  logic                  push_ok;
  logic                  drop;

  always_comb begin
    sum     = acc + AccW'(y_in);
    word    = sum[AccW-1:DECIM_LOG2];
    dump    = in_en && (phase == '1);
    full    = (fill_q == 3'(DEPTH));
    pop     = (fill_q != 3'd0) && dout_ready;
    // When full, a push only lands if the head is leaving on the same edge.
    push_ok = dump && (!full || pop);
    drop    = dump && full && !pop;
    fill_d  = fill_q;
    if (push_ok && !pop) begin
      fill_d = fill_q + 3'd1;
    end else if (!push_ok && pop) begin
      fill_d = fill_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase  <= '0;
      acc    <= '0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      fill_q <= 3'd0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= 24'd0;
      end
    end else begin
      if (in_en) begin
        if (dump) begin
          acc   <= '0;
          phase <= '0;
        end else begin
          acc   <= sum;
          phase <= phase + 1'b1;
        end
      end
      if (push_ok) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      fill_q <= fill_d;
      // A drop on the same edge as a clear leaves the flag set.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign dout       = mem[rd_ptr];
  assign dout_valid = (fill_q != 3'd0);
  assign fill       = fill_q;
  assign ovf        = ovf_q;

endmodule
